ahb_lite_resp_mux: RTL and testbench
====================================

// Module: ahb_lite_resp_mux
// PURPOSE
// - Parametrised AHB-Lite slave-to-master response multiplexer with integrated default slave.
// - Tracks the data phase and routes HRDATA/HRESP/HREADY from the slave addressed in the previous address phase.
// - Answers unmapped or multiply-selected active transfers with a two-cycle ERROR.
// - Sits between the address decoder and the master; replaces the fixed 4-slave response mux.
// PARAMETERS
// - NUM_SLAVES      4    number of slave ports, 1..16
// - BUS_WIDTH       32   HRDATA width in bits
// - TIMEOUT_CYCLES  16   wait-state limit per data phase, >=2; used only with AHB_MUX_TIMEOUT_EN
// PORTS
// - HCLK         in   1                     bus clock; all state on rising edge
// - HRESETn      in   1                     asynchronous active-low reset
// - HSEL         in   NUM_SLAVES            decoder selects, address phase, one-hot expected
// - HTRANS       in   2                     master transfer type, address phase
// - HRDATA_S     in   NUM_SLAVES*BUS_WIDTH  slave read data; slave i at [i*BUS_WIDTH +: BUS_WIDTH]
// - HRESP_S      in   NUM_SLAVES            slave responses, 1 = ERROR
// - HREADYOUT_S  in   NUM_SLAVES            slave ready outputs
// - HRDATA       out  BUS_WIDTH             read data to master
// - HRESP        out  1                     response to master
// - HREADY       out  1                     ready to master and all slaves
// - HTIMEOUT     out  1                     one-cycle pulse on wait-state timeout; constant 0 without the macro
// BEHAVIOUR
// - Reset (async, HRESETn=0): state DP_IDLE, sel_idx=0, wait counter=0.
// - Reset outputs: HREADY=1, HRESP=0, HRDATA=0, HTIMEOUT=0.
// - Outputs are combinational from registered state plus slave inputs; no added latency.
// - Address-phase signals (HSEL, HTRANS) are sampled only on edges where HREADY=1.
// - While HREADY=0, state and sel_idx hold, except for the ERR and timeout transitions listed below.
// - Sampling rules (on HREADY=1 edges):
//   - HTRANS=IDLE/BUSY (HTRANS[1]=0) -> DP_IDLE.
//   - HTRANS[1]=1 and exactly one HSEL bit set -> DP_SLAVE, sel_idx=index of that bit.
//   - HTRANS[1]=1 and HSEL zero or >1 bit set -> DP_ERR1.
// - HSEL with HTRANS[1]=0 still selects nobody; no slave response is routed.
// - State outputs:
//   - DP_IDLE: HREADY=1, HRESP=0, HRDATA=0.
//   - DP_SLAVE: HRDATA/HRESP/HREADY = slave sel_idx values, unmodified, including the slave's own two-cycle ERROR.
//   - DP_ERR1: HREADY=0, HRESP=1, HRDATA=0; always moves to DP_ERR2 next cycle.
//   - DP_ERR2: HREADY=1, HRESP=1, HRDATA=0; next state comes from sampling.
// - Back-to-back transfers: the address phase presented during DP_ERR2 or the last DP_SLAVE cycle is sampled normally.
// - A master that cancels to IDLE during ERR1 yields DP_IDLE after ERR2.
// - Slaves not selected are ignored entirely; X on them must not reach the outputs.
// - sel_idx width: $clog2(NUM_SLAVES), minimum 1. Index compare uses no truncation.
// - Reset asserted mid-transfer aborts it immediately; outputs return to reset values asynchronously.
// CONFIGURATION
// - Macro: AHB_MUX_TIMEOUT_EN.
// - Defined:
//   - A wait counter runs in DP_SLAVE; it increments on each cycle with HREADYOUT_S[sel_idx]=0 and clears otherwise.
//   - When the counter reaches TIMEOUT_CYCLES, the next state is DP_ERR1 and HTIMEOUT=1 for that one edge-following cycle.
//   - The mux then completes the two-cycle ERROR itself; later slave outputs for that transfer are ignored.
//   - The counter clears on leaving DP_SLAVE.
// - Undefined: no counter logic; DP_SLAVE waits indefinitely; HTIMEOUT tied 0.
// TESTING
// - Reset: HRESETn=0 mid-transfer -> HREADY=1, HRESP=0, HRDATA=0 in the same cycle.
// - NONSEQ, HSEL=4'b0100, slave2 HRDATA=32'hDEADBEEF, one wait state -> HREADY 0 then 1.
//   - HRDATA=32'hDEADBEEF on the ready cycle.
//   - Slave0 data never appears.
// - NONSEQ, HSEL=0 -> cycle n+1: HREADY=0, HRESP=1; cycle n+2: HREADY=1, HRESP=1; then an OKAY transfer to slave1.
// - NONSEQ, HSEL=4'b0011 -> same two-cycle ERROR; both slaves' outputs ignored.
// - IDLE with HSEL=4'b0001, slave0 HREADYOUT=0 -> HREADY=1, HRESP=0.
//   - Address held during a waited slave3 phase is sampled once only.
// - Macro on, TIMEOUT_CYCLES=4, slave1 holds HREADYOUT=0 -> after 4 wait cycles HTIMEOUT pulses.
//   - ERR1 then ERR2 follow.
//   - Macro off, same stimulus: HREADY stays 0 and HTIMEOUT stays 0.

Source files
------------

// File: rtl/ahb_lite_resp_mux_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahb_lite_resp_mux_if : decoder/slave-side bundle for ahb_lite_resp_mux  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface ahb_lite_resp_mux_if #(
  parameter int NUM_SLAVES = 4,
  parameter int BUS_WIDTH  = 32
);
  logic [NUM_SLAVES-1:0]           HSEL;
  logic [1:0]                      HTRANS;
  logic [NUM_SLAVES*BUS_WIDTH-1:0] HRDATA_S;
  logic [NUM_SLAVES-1:0]           HRESP_S;
  logic [NUM_SLAVES-1:0]           HREADYOUT_S;
  logic [BUS_WIDTH-1:0]            HRDATA;
  logic                            HRESP;
  logic                            HREADY;
  logic                            HTIMEOUT;

  modport slave (
    input  HSEL, HTRANS, HRDATA_S, HRESP_S, HREADYOUT_S,
    output HRDATA, HRESP, HREADY, HTIMEOUT
  );

  modport master (
    output HSEL, HTRANS, HRDATA_S, HRESP_S, HREADYOUT_S,
    input  HRDATA, HRESP, HREADY, HTIMEOUT
  );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_resp_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahb_lite_resp_mux : AHB-Lite response mux with built-in default slave;  |
// | optional wait-state timeout under AHB_MUX_TIMEOUT_EN.                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ahb_lite_resp_mux #(
  parameter int NUM_SLAVES     = 4,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic          HCLK,
  input  wire logic          HRESETn,
  ahb_lite_resp_mux_if.slave bus
);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ahb_lite_resp_mux: parameter out of range");
  end

  typedef enum logic [1:0] {
    DP_IDLE  = 2'd0,
    DP_SLAVE = 2'd1,
    DP_ERR1  = 2'd2,
    DP_ERR2  = 2'd3
  } dp_state_e;

  dp_state_e            state_q, state_d;
  logic [SEL_W-1:0]     sel_idx_q, sel_idx_d;
  logic [4:0]           sel_cnt;
  logic [SEL_W-1:0]     hsel_idx;
  logic                 hsel_one;
  logic [BUS_WIDTH-1:0] slv_rdata;
  logic                 slv_resp;
  logic                 slv_ready;
  logic [BUS_WIDTH-1:0] hrdata;
  logic                 hresp;
  logic                 hready;
  logic                 timeout_hit;
  logic                 unused_htrans0;

  assign unused_htrans0 = bus.HTRANS[0];

  always_comb begin
    sel_cnt  = '0;
    hsel_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (bus.HSEL[i]) begin
        sel_cnt  = sel_cnt + 5'd1;
        hsel_idx = SEL_W'(i);
      end
    end
    hsel_one = (sel_cnt == 5'd1);
  end

  // Only the addressed slave is looked at, so X on the others stays out.
  always_comb begin
    slv_rdata = '0;
    slv_resp  = 1'b0;
    slv_ready = 1'b1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (32'(sel_idx_q) == 32'(i)) begin
        slv_rdata = bus.HRDATA_S[i*BUS_WIDTH +: BUS_WIDTH];
        slv_resp  = bus.HRESP_S[i];
        slv_ready = bus.HREADYOUT_S[i];
      end
    end
  end

  always_comb begin
    hrdata = '0;
    hresp  = 1'b0;
    hready = 1'b1;
    case (state_q)
      DP_SLAVE: begin
        hrdata = slv_rdata;
        hresp  = slv_resp;
        hready = slv_ready;
      end
      DP_ERR1: begin
        hresp  = 1'b1;
        hready = 1'b0;
      end
      DP_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  assign bus.HRDATA = hrdata;
  assign bus.HRESP  = hresp;
  assign bus.HREADY = hready;

  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    if (state_q == DP_ERR1) begin
      state_d = DP_ERR2;
    end else if (timeout_hit) begin
      state_d = DP_ERR1;
    end else if (hready) begin
      if (!bus.HTRANS[1]) begin
        state_d = DP_IDLE;
      end else if (hsel_one) begin
        state_d   = DP_SLAVE;
        sel_idx_d = hsel_idx;
      end else begin
        state_d = DP_ERR1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= DP_IDLE;
      sel_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_idx_q <= sel_idx_d;
    end
  end

`ifdef AHB_MUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q;

  // Counter clears whenever the slave is ready or the data phase is not a slave one.
  always_comb begin
    wait_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (state_q == DP_SLAVE && !slv_ready) begin
      if (int'(wait_cnt_q) + 1 >= TIMEOUT_CYCLES) begin
        timeout_hit = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_hit;
    end
  end

  assign bus.HTIMEOUT = timeout_q;
`else
  assign timeout_hit  = 1'b0;
  assign bus.HTIMEOUT = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_resp_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ahb_lite_resp_mux : directed vectors for ahb_lite_resp_mux           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ahb_lite_resp_mux;
  localparam int NS = 4;
  localparam int BW = 32;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic HCLK;
  logic HRESETn;
  int   n_vec;
  int   n_err;

  ahb_lite_resp_mux_if #(.NUM_SLAVES(NS), .BUS_WIDTH(BW)) bus ();

  ahb_lite_resp_mux #(
    .NUM_SLAVES    (NS),
    .BUS_WIDTH     (BW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr(input logic [1:0] trans, input logic [NS-1:0] sel);
    bus.HTRANS = trans;
    bus.HSEL   = sel;
  endtask

  task automatic set_slave(input int idx, input logic [BW-1:0] data,
                           input logic resp, input logic rdy);
    bus.HRDATA_S[idx*BW +: BW] = data;
    bus.HRESP_S[idx]           = resp;
    bus.HREADYOUT_S[idx]       = rdy;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    HRESETn = 1'b0;
    bus.HSEL = '0;
    bus.HTRANS = T_IDLE;
    bus.HRDATA_S = '0;
    bus.HRESP_S = '0;
    bus.HREADYOUT_S = '1;
    set_slave(0, 32'h0000_0BAD, 1'b0, 1'b1);
    #2;
    check_val("rst_hready", 32'(bus.HREADY), 32'd1);
    check_val("rst_hresp", 32'(bus.HRESP), 32'd0);
    check_val("rst_hrdata", bus.HRDATA, 32'd0);
    check_val("rst_htimeout", 32'(bus.HTIMEOUT), 32'd0);
    tick();
    tick();
    HRESETn = 1'b1;
    tick();

    // Slave2 read with one wait state; slave3 floats to X meanwhile.
    set_slave(3, 'x, 1'bx, 1'bx);
    addr(T_NONSEQ, 4'b0100);
    set_slave(2, 32'h0, 1'b0, 1'b0);
    #1 check_val("A_addr_hready", 32'(bus.HREADY), 32'd1);
    tick();
    addr(T_IDLE, 4'b0000);
    #1;
    check_val("A_wait_hready", 32'(bus.HREADY), 32'd0);
    check_val("A_wait_hrdata", bus.HRDATA, 32'h0);
    tick();
    set_slave(2, 32'hDEAD_BEEF, 1'b0, 1'b1);
    #1;
    check_val("A_done_hready", 32'(bus.HREADY), 32'd1);
    check_val("A_done_hrdata", bus.HRDATA, 32'hDEAD_BEEF);
    check_val("A_done_hresp", 32'(bus.HRESP), 32'd0);
    tick();
    #1 check_val("A_idle_hrdata", bus.HRDATA, 32'h0);

    // Unmapped address, then an OKAY transfer to slave1 sampled during ERR2.
    addr(T_NONSEQ, 4'b0000);
    tick();
    addr(T_NONSEQ, 4'b0010);
    set_slave(1, 32'h1111_2222, 1'b0, 1'b1);
    #1;
    check_val("B_err1_hready", 32'(bus.HREADY), 32'd0);
    check_val("B_err1_hresp", 32'(bus.HRESP), 32'd1);
    check_val("B_err1_hrdata", bus.HRDATA, 32'h0);
    tick();
    #1;
    check_val("B_err2_hready", 32'(bus.HREADY), 32'd1);
    check_val("B_err2_hresp", 32'(bus.HRESP), 32'd1);
    tick();
    addr(T_IDLE, 4'b0000);
    #1;
    check_val("B_s1_hready", 32'(bus.HREADY), 32'd1);
    check_val("B_s1_hresp", 32'(bus.HRESP), 32'd0);
    check_val("B_s1_hrdata", bus.HRDATA, 32'h1111_2222);
    tick();

    // Multiple selects; master cancels to IDLE during ERR1.
    addr(T_NONSEQ, 4'b0011);
    set_slave(0, 'x, 1'bx, 1'bx);
    set_slave(1, 'x, 1'bx, 1'bx);
    tick();
    addr(T_IDLE, 4'b0000);
    #1;
    check_val("C_err1_hready", 32'(bus.HREADY), 32'd0);
    check_val("C_err1_hresp", 32'(bus.HRESP), 32'd1);
    check_val("C_err1_hrdata", bus.HRDATA, 32'h0);
    tick();
    #1;
    check_val("C_err2_hready", 32'(bus.HREADY), 32'd1);
    check_val("C_err2_hresp", 32'(bus.HRESP), 32'd1);
    tick();
    #1;
    check_val("C_idle_hready", 32'(bus.HREADY), 32'd1);
    check_val("C_idle_hresp", 32'(bus.HRESP), 32'd0);
    set_slave(1, 32'h0, 1'b0, 1'b1);

    // IDLE with HSEL set must not route a stalled slave0.
    addr(T_IDLE, 4'b0001);
    set_slave(0, 32'h0000_0BAD, 1'b0, 1'b0);
    tick();
    #1;
    check_val("D_idle_hready", 32'(bus.HREADY), 32'd1);
    check_val("D_idle_hresp", 32'(bus.HRESP), 32'd0);
    set_slave(0, 32'h0000_0BAD, 1'b0, 1'b1);

    // Next address held through a waited slave3 phase; slave ERROR passes through.
    addr(T_NONSEQ, 4'b1000);
    set_slave(3, 32'h3333_3333, 1'b0, 1'b0);
    tick();
    #1 check_val("D_w1_hready", 32'(bus.HREADY), 32'd0);
    tick();
    #1;
    check_val("D_w2_hready", 32'(bus.HREADY), 32'd0);
    check_val("D_w2_hrdata", bus.HRDATA, 32'h3333_3333);
    set_slave(3, 32'h3333_3333, 1'b0, 1'b1);
    #1 check_val("D_w3_hready", 32'(bus.HREADY), 32'd1);
    tick();
    addr(T_IDLE, 4'b0000);
    set_slave(3, 32'h4444_4444, 1'b1, 1'b0);
    #1;
    check_val("D_e1_hready", 32'(bus.HREADY), 32'd0);
    check_val("D_e1_hresp", 32'(bus.HRESP), 32'd1);
    tick();
    set_slave(3, 32'h4444_4444, 1'b1, 1'b1);
    #1;
    check_val("D_e2_hready", 32'(bus.HREADY), 32'd1);
    check_val("D_e2_hresp", 32'(bus.HRESP), 32'd1);
    check_val("D_e2_hrdata", bus.HRDATA, 32'h4444_4444);
    tick();
    #1;
    check_val("D_end_hready", 32'(bus.HREADY), 32'd1);
    check_val("D_end_hresp", 32'(bus.HRESP), 32'd0);

    // Reset asserted in the middle of a waited slave2 phase.
    addr(T_NONSEQ, 4'b0100);
    set_slave(2, 32'hCAFE_F00D, 1'b1, 1'b0);
    tick();
    addr(T_IDLE, 4'b0000);
    #1;
    check_val("R_pre_hready", 32'(bus.HREADY), 32'd0);
    check_val("R_pre_hrdata", bus.HRDATA, 32'hCAFE_F00D);
    HRESETn = 1'b0;
    #1;
    check_val("R_hready", 32'(bus.HREADY), 32'd1);
    check_val("R_hresp", 32'(bus.HRESP), 32'd0);
    check_val("R_hrdata", bus.HRDATA, 32'h0);
    tick();
    HRESETn = 1'b1;
    set_slave(2, 32'h0, 1'b0, 1'b1);
    tick();

    // Slave1 stalls indefinitely.
    addr(T_NONSEQ, 4'b0010);
    set_slave(1, 32'h0000_0055, 1'b0, 1'b0);
    tick();
    addr(T_IDLE, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      #1;
      check_val("T_wait_hready", 32'(bus.HREADY), 32'd0);
      check_val("T_wait_htimeout", 32'(bus.HTIMEOUT), 32'd0);
      tick();
    end
`ifdef AHB_MUX_TIMEOUT_EN
    #1;
    check_val("T_err1_htimeout", 32'(bus.HTIMEOUT), 32'd1);
    check_val("T_err1_hready", 32'(bus.HREADY), 32'd0);
    check_val("T_err1_hresp", 32'(bus.HRESP), 32'd1);
    check_val("T_err1_hrdata", bus.HRDATA, 32'h0);
    tick();
    #1;
    check_val("T_err2_htimeout", 32'(bus.HTIMEOUT), 32'd0);
    check_val("T_err2_hready", 32'(bus.HREADY), 32'd1);
    check_val("T_err2_hresp", 32'(bus.HRESP), 32'd1);
    tick();
    #1;
    check_val("T_idle_hready", 32'(bus.HREADY), 32'd1);
    check_val("T_idle_hresp", 32'(bus.HRESP), 32'd0);
`else
    for (int k = 0; k < 4; k++) begin
      #1;
      check_val("T_hold_hready", 32'(bus.HREADY), 32'd0);
      check_val("T_hold_htimeout", 32'(bus.HTIMEOUT), 32'd0);
      tick();
    end
    set_slave(1, 32'h0000_0055, 1'b0, 1'b1);
    #1;
    check_val("T_rel_hready", 32'(bus.HREADY), 32'd1);
    check_val("T_rel_hrdata", bus.HRDATA, 32'h0000_0055);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
